// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the prod_accum streaming accumulator.
package prod_accum_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_e;

  localparam int unsigned PROD_W_DEF = 25;
  localparam int unsigned ACC_W_DEF  = 32;
  localparam int unsigned CNT_W_DEF  = 8;

endpackage

// File: rtl/prod_accum_if.sv
// Product-in / frame-result-out handshake bundle for prod_accum.
interface prod_accum_if
  import prod_accum_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // Producer of products and consumer of results.
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/prod_accum_add.sv
// ACC_W+1-bit accumulate adder with carry-out.
// PROD_ACCUM_SATURATE_EN: clamp the sum to all-ones on carry instead of wrapping.
module prod_accum_add
  import prod_accum_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned PROD_W = PROD_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
  assign o_carry = w_full[ACC_W];

`ifdef PROD_ACCUM_SATURATE_EN
  // A clamped all-ones accumulator re-carries on any nonzero product, so it stays clamped.
  assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Streaming frame accumulator for multiplier products with a registered result stage.
// Optional PROD_ACCUM_SATURATE_EN (in prod_accum_add) selects clamping over wrapping.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  prod_accum_if.slave bus
);

  state_e             r_state, w_state_d;
  logic [ACC_W-1:0]   r_acc, w_acc_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d, w_cnt_inc;
  logic               r_ovf, w_ovf_d, w_ovf_inc;

  logic               r_out_valid, w_out_valid_d;
  logic [ACC_W-1:0]   r_out_sum, w_out_sum_d;
  logic [CNT_W-1:0]   r_out_count, w_out_count_d;
  logic               r_out_ovf, w_out_ovf_d;

  logic               w_in_ready, w_in_acc;
  logic [ACC_W-1:0]   w_add_a, w_add_sum;
  logic               w_add_carry;

  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_in_acc   = bus.in_valid & w_in_ready;
  assign w_add_a    = (r_state == S_ACC) ? r_acc : '0;

  prod_accum_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_add (
    .i_acc   (w_add_a),
    .i_prod  (bus.in_prod),
    .o_sum   (w_add_sum),
    .o_carry (w_add_carry)
  );

  always_comb begin
    w_state_d     = r_state;
    w_acc_d       = r_acc;
    w_cnt_d       = r_cnt;
    w_ovf_d       = r_ovf;
    w_out_sum_d   = r_out_sum;
    w_out_count_d = r_out_count;
    w_out_ovf_d   = r_out_ovf;
    w_out_valid_d = r_out_valid & ~bus.out_ready;
    w_cnt_inc     = CNT_W'(1);
    w_ovf_inc     = w_add_carry;

    unique case (r_state)
      S_IDLE: begin
        w_cnt_inc = CNT_W'(1);
        w_ovf_inc = w_add_carry;
      end
      S_ACC: begin
        w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
        w_ovf_inc = r_ovf | w_add_carry;
      end
    endcase

    if (w_in_acc) begin
      if (bus.in_last) begin
        // A new result overrides the clear from a same-cycle output accept.
        w_out_valid_d = 1'b1;
        w_out_sum_d   = w_add_sum;
        w_out_count_d = w_cnt_inc;
        w_out_ovf_d   = w_ovf_inc;
        w_state_d     = S_IDLE;
        w_acc_d       = '0;
        w_cnt_d       = '0;
        w_ovf_d       = 1'b0;
      end else begin
        w_state_d = S_ACC;
        w_acc_d   = w_add_sum;
        w_cnt_d   = w_cnt_inc;
        w_ovf_d   = w_ovf_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_acc       <= w_acc_d;
      r_cnt       <= w_cnt_d;
      r_ovf       <= w_ovf_d;
      r_out_valid <= w_out_valid_d;
      r_out_sum   <= w_out_sum_d;
      r_out_count <= w_out_count_d;
      r_out_ovf   <= w_out_ovf_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench for prod_accum: default-width DUT with a result scoreboard,
// plus a narrow DUT (ACC_W=26, CNT_W=2) for overflow and count saturation.
module tb_prod_accum;
  import prod_accum_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prod_accum_if bus_d ();
  prod_accum_if #(.PROD_W(25), .ACC_W(26), .CNT_W(2)) bus_s ();

  prod_accum u_def (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  prod_accum #(
    .PROD_W (25),
    .ACC_W  (26),
    .CNT_W  (2)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [24:0] prod;
    logic        last;
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every result taken by the consumer is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus_d.out_valid === 1'b1 && bus_d.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", bus_d.out_valid, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check("res_sum", bus_d.out_sum, mon_e.sum);
        check("res_count", bus_d.out_count, mon_e.cnt);
        check("res_ovf", bus_d.out_ovf, mon_e.ovf);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts the beat.
  task automatic send(input logic [24:0] prod, input logic last, input logic [31:0] es,
                      input logic [7:0] ec, input logic eo);
    int   waited;
    exp_t e;
    waited         = 0;
    bus_d.in_valid = 1'b1;
    bus_d.in_prod  = prod;
    bus_d.in_last  = last;
    @(negedge clk);
    if (bus_d.out_ready) check("in_ready_full_rate", bus_d.in_ready, 1'b1);
    while (!bus_d.in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!bus_d.in_ready) begin
      check("accept_timeout", bus_d.in_ready, 1'b1);
    end else if (last) begin
      e.sum = es;
      e.cnt = ec;
      e.ovf = eo;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus_d.in_valid = 1'b0;
    bus_d.in_last  = 1'b0;
  endtask

  // Full-rate frame of n equal terms into the narrow DUT, then check the result.
  task automatic small_frame(input int n, input logic [24:0] p, input string nm,
                             input logic [25:0] es, input logic [1:0] ec, input logic eo);
    for (int i = 0; i < n; i++) begin
      bus_s.in_valid = 1'b1;
      bus_s.in_prod  = p;
      bus_s.in_last  = (i == n - 1);
      @(posedge clk);
      #1;
    end
    bus_s.in_valid = 1'b0;
    bus_s.in_last  = 1'b0;
    @(negedge clk);
    check({nm, "_valid"}, bus_s.out_valid, 1'b1);
    check({nm, "_sum"}, bus_s.out_sum, es);
    check({nm, "_count"}, bus_s.out_count, ec);
    check({nm, "_ovf"}, bus_s.out_ovf, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] msum;
    logic [24:0] p;
    int          len;

    vecs[0] = '{25'd16769025, 1'b1, 32'd16769025, 8'd1, 1'b0};
    vecs[1] = '{25'd16769025, 1'b0, 32'd0, 8'd0, 1'b0};
    vecs[2] = '{25'd16769025, 1'b0, 32'd0, 8'd0, 1'b0};
    vecs[3] = '{25'd16769025, 1'b1, 32'd50307075, 8'd3, 1'b0};
    vecs[4] = '{25'd100, 1'b0, 32'd0, 8'd0, 1'b0};
    vecs[5] = '{25'd200, 1'b1, 32'd300, 8'd2, 1'b0};
    vecs[6] = '{25'd0, 1'b1, 32'd0, 8'd1, 1'b0};
    vecs[7] = '{25'd33554431, 1'b0, 32'd0, 8'd0, 1'b0};
    vecs[8] = '{25'd33554431, 1'b1, 32'd67108862, 8'd2, 1'b0};
    vecs[9] = '{25'd1, 1'b1, 32'd1, 8'd1, 1'b0};

    rst             = 1'b1;
    bus_d.in_valid  = 1'b0;
    bus_d.in_prod   = '0;
    bus_d.in_last   = 1'b0;
    bus_d.out_ready = 1'b1;
    bus_s.in_valid  = 1'b0;
    bus_s.in_prod   = '0;
    bus_s.in_last   = 1'b0;
    bus_s.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus_d.out_valid, 1'b0);
    check("rst_out_sum", bus_d.out_sum, 32'd0);
    check("rst_out_count", bus_d.out_count, 8'd0);
    check("rst_out_ovf", bus_d.out_ovf, 1'b0);
    check("rst_in_ready", bus_d.in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus_d.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Table of frames, driven back to back at full rate.
    for (int i = 0; i < 10; i++) send(vecs[i].prod, vecs[i].last, vecs[i].sum, vecs[i].cnt,
                                      vecs[i].ovf);
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Backpressure: pending result holds and stalls the next frame's first beat.
    bus_d.out_ready = 1'b0;
    send(25'd5, 1'b1, 32'd5, 8'd1, 1'b0);
    bus_d.in_valid = 1'b1;
    bus_d.in_prod  = 25'd9;
    bus_d.in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", bus_d.in_ready, 1'b0);
      check("bp_out_valid", bus_d.out_valid, 1'b1);
      check("bp_hold_sum", bus_d.out_sum, 32'd5);
      @(posedge clk);
      #1;
    end
    bus_d.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(25'd11, 1'b1, 32'd20, 8'd2, 1'b0);

    // Random frames checked against a running-sum model.
    for (int f = 0; f < 4; f++) begin
      len  = int'($urandom_range(1, 4));
      msum = '0;
      for (int b = 0; b < len; b++) begin
        p    = 25'($urandom_range(0, 33554431));
        msum = msum + 32'(p);
        send(p, (b == len - 1), msum, 8'(b + 1), 1'b0);
      end
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Reset discards a pending (stalled) result.
    bus_d.out_ready = 1'b0;
    send(25'd3, 1'b0, 32'd0, 8'd0, 1'b0);
    send(25'd4, 1'b1, 32'd7, 8'd2, 1'b0);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("rst_drop_valid", bus_d.out_valid, 1'b0);
    check("rst_drop_sum", bus_d.out_sum, 32'd0);
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus_d.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-frame after two terms, then a one-term frame.
    send(25'd50, 1'b0, 32'd0, 8'd0, 1'b0);
    send(25'd60, 1'b0, 32'd0, 8'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(25'd7, 1'b1, 32'd7, 8'd1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Narrow DUT: boundary just below 2^26, overflow, and count saturation.
    small_frame(4, 25'd16769025, "no_ovf", 26'd67076100, 2'd3, 1'b0);
`ifdef PROD_ACCUM_SATURATE_EN
    small_frame(5, 25'd16769025, "ovf", 26'd67108863, 2'd3, 1'b1);
`else
    small_frame(5, 25'd16769025, "ovf", 26'd16736261, 2'd3, 1'b1);
`endif
    small_frame(5, 25'd1, "cnt_sat", 26'd5, 2'd3, 1'b0);
    small_frame(1, 25'd42, "post_ovf_clear", 26'd42, 2'd1, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
